acc_store_unit: RTL and testbench
=================================

Name: acc_store_unit

Overview:
Read side of the accumulator register. On a store request, it snapshots the accumulator output and the target address. It then serialises the word into byte-wide data-memory writes over a valid/ready handshake and signals completion to the control unit. It sits between the accumulator output (acc_out), the control unit's store decode and the byte-wide data-memory write port.

Parameters:
DATA_W, 32, accumulator word width; must be an integer multiple of BYTE_W
BYTE_W, 8, memory write-port data width
ADDR_W, 16, byte address width
NBYTES, DATA_W/BYTE_W (derived localparam, not overridable), bytes per store

Ports:
execlk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
acc_out  input  DATA_W  current accumulator value
st_req  input  1  store request from control unit; sampled only when st_busy=0
st_addr  input  ADDR_W  base byte address; sampled with st_req
st_busy  output  1  high while a store is in progress (SEND or DONE)
st_done  output  1  one-cycle pulse: all bytes accepted by memory
mem_wr_valid  output  1  byte write request
mem_wr_ready  input  1  memory accepts the byte when valid and ready are both high at the clock edge
mem_wr_addr  output  ADDR_W  byte address of current write
mem_wr_data  output  BYTE_W  byte data of current write

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; word, address and count registers cleared.
  - st_busy=0, st_done=0, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0.
  - Applies immediately, including mid-transfer. An interrupted store is abandoned, never resumed; bytes already accepted remain written.
- States: IDLE, SEND, DONE. Outputs decode from registered state only; no combinational path from any input to any output.
- IDLE:
  - st_busy=0, mem_wr_valid=0.
  - If st_req=1: capture word_r<=acc_out, base_r<=st_addr, cnt<=0, go to SEND.
- SEND:
  - st_busy=1, mem_wr_valid=1.
  - mem_wr_addr = base_r + cnt, computed modulo 2^ADDR_W (wraps from all-ones to 0).
  - mem_wr_data = word_r[cnt*BYTE_W +: BYTE_W]. Little-endian: byte 0 (LSBs) goes to the base address.
  - While valid and ready=0, address and data are held stable and valid stays high; there is no timeout.
  - On accept: if cnt==NBYTES-1, go to DONE; else cnt<=cnt+1.
- DONE: st_done=1 for exactly one cycle, st_busy=1, mem_wr_valid=0. Next state IDLE.
- Latency: st_req sampled at edge 0. With ready held high, bytes are accepted at edges 1..NBYTES and st_done is high in the cycle after edge NBYTES (cycle 5 for defaults). A new request can be accepted at the edge that ends the DONE cycle is NOT allowed; earliest acceptance is when st_busy=0 again.
- Snapshot: acc_out changes after capture do not affect the store in flight.
- st_req while st_busy=1 is ignored, not queued. The control unit holds or re-issues it.
- mem_wr_ready while valid=0 is ignored.
- No back-to-back stores: at least one IDLE cycle separates consecutive stores.

Decomposition:
- Shared package acc_pkg:
  - state enum (IDLE, SEND, DONE), 2-bit encoding
  - default width constants DATA_W/BYTE_W/ADDR_W, so accumulator, ALU and store unit stay in agreement
- Single module, no sub-module. The byte-select mux is a parameterised slice and does not justify its own block.

Test Plan:
- Reset: hold rst=0 and toggle execlk -> all outputs 0. Release rst, no st_req -> outputs stay 0, state IDLE.
- Basic store: acc_out=32'hDEADBEEF, st_addr=16'h0100, st_req pulse, ready=1 -> writes (0100,EF), (0101,BE), (0102,AD), (0103,DE) on consecutive cycles; st_done pulses the following cycle; st_busy high for 5 cycles.
- Backpressure: same store with ready low for 3 cycles on byte 2 -> addr 0102 / data AD held stable with valid high throughout; total busy time 8 cycles; byte order unchanged.
- Wrap and snapshot: st_addr=16'hFFFE, acc_out=32'h11223344, with acc_out changed to 0 after capture -> writes (FFFE,44), (FFFF,33), (0000,22), (0001,11).
- Request while busy: second st_req during SEND and during DONE -> ignored; exactly 4 writes and one st_done. A request after st_busy falls -> accepted.
- Reset mid-operation: assert rst=0 after byte 1 is accepted, during ready=0 -> mem_wr_valid drops asynchronously; no st_done. After release, the unit is in IDLE and a new store completes normally.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared accumulator datapath constants and the store-unit state encoding,
// so the accumulator, ALU and store unit agree on widths.
package acc_pkg;

  localparam int ACC_DATA_W = 32;
  localparam int ACC_BYTE_W = 8;
  localparam int ACC_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } store_state_e;

endpackage

// File: rtl/acc_store_unit.sv
// Accumulator store path: snapshots acc_out and the target address, then
// writes the word little-endian, one byte per accepted valid/ready beat.
module acc_store_unit
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int BYTE_W = ACC_BYTE_W,
  parameter int ADDR_W = ACC_ADDR_W
) (
  input  logic              execlk,
  input  logic              rst,
  input  logic [DATA_W-1:0] acc_out,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  output logic              st_busy,
  output logic              st_done,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [BYTE_W-1:0] mem_wr_data
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  store_state_e      state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge execlk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (st_req) begin
          word_d  = acc_out;
          base_d  = st_addr;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (mem_wr_ready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend only on registers; address arithmetic wraps at 2^ADDR_W.
  assign st_busy      = (state_q != ST_IDLE);
  assign st_done      = (state_q == ST_DONE);
  assign mem_wr_valid = (state_q == ST_SEND);
  assign mem_wr_addr  = base_q + ADDR_W'(cnt_q);
  assign mem_wr_data  = word_q[int'(cnt_q) * BYTE_W +: BYTE_W];

endmodule

// File: tb/tb_acc_store_unit.sv
// Self-checking bench for acc_store_unit: directed scenarios plus randomized
// stores with random backpressure, checked against a byte-list model.
module tb_acc_store_unit;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 16;
  localparam int NB = DW / BW;

  logic          execlk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] acc_out = '0;
  logic          st_req = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic          st_busy;
  logic          st_done;
  logic          mem_wr_valid;
  logic          mem_wr_ready = 1'b0;
  logic [AW-1:0] mem_wr_addr;
  logic [BW-1:0] mem_wr_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  done_cnt = 0;
  int  busy_cnt = 0;

  acc_store_unit #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) dut (
    .execlk      (execlk),
    .rst         (rst),
    .acc_out     (acc_out),
    .st_req      (st_req),
    .st_addr     (st_addr),
    .st_busy     (st_busy),
    .st_done     (st_done),
    .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );

  always #5 execlk = ~execlk;

  // Inputs change 1 time unit after the rising edge, so values seen here are
  // exactly what the next rising edge will act on.
  always @(negedge execlk) begin
    if (mem_wr_valid && mem_wr_ready) wr_q.push_back('{a: mem_wr_addr, d: mem_wr_data});
    if (st_done) done_cnt++;
    if (st_busy) busy_cnt++;
  end

  // Reference: byte i of a store lands at (base + i) mod 2^AW, taken little-endian.
  function automatic wr_t model_wr(input logic [DW-1:0] w, input logic [AW-1:0] base, input int i);
    wr_t r;
    r.a = AW'((int'(base) + i) % (1 << AW));
    r.d = BW'((w >> (BW * i)) & ((1 << BW) - 1));
    return r;
  endfunction

  task automatic start_store(input logic [DW-1:0] w, input logic [AW-1:0] a);
    @(posedge execlk); #1;
    acc_out = w;
    st_addr = a;
    st_req  = 1'b1;
    @(posedge execlk); #1;
    st_req  = 1'b0;
    acc_out = $urandom;
    st_addr = AW'($urandom);
  endtask

  task automatic wait_idle(output bit ok, input int budget);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge execlk);
      if (!st_busy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge execlk);
    vectors++; if (st_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", st_busy); end
    vectors++; if (st_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", st_done); end
    vectors++; if (mem_wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", mem_wr_valid); end
    vectors++; if (mem_wr_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_wr_addr); end
    vectors++; if (mem_wr_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", mem_wr_data); end
    @(posedge execlk); #1;
    rst = 1'b1;
    repeat (3) @(negedge execlk);
    vectors++; if ({st_busy, st_done, mem_wr_valid} !== 3'b000) begin
      miscompares++; $display("FAIL idle_after_reset: got busy/done/valid=%b expected 000", {st_busy, st_done, mem_wr_valid});
    end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_basic();
    wr_t exp_w;
    mem_wr_ready = 1'b1;
    start_store(32'hDEADBEEF, 16'h0100);
    for (int k = 0; k < NB; k++) begin
      @(negedge execlk);
      exp_w = model_wr(32'hDEADBEEF, 16'h0100, k);
      vectors++;
      if (mem_wr_valid !== 1'b1 || st_done !== 1'b0 || st_busy !== 1'b1 || mem_wr_addr !== exp_w.a || mem_wr_data !== exp_w.d) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got v=%b done=%b busy=%b %h/%h expected v=1 done=0 busy=1 %h/%h",
                 k, mem_wr_valid, st_done, st_busy, mem_wr_addr, mem_wr_data, exp_w.a, exp_w.d);
      end
    end
    @(negedge execlk);
    vectors++; if ({st_done, st_busy, mem_wr_valid} !== 3'b110) begin
      miscompares++; $display("FAIL basic_done_cycle: got done/busy/valid=%b expected 110", {st_done, st_busy, mem_wr_valid});
    end
    @(negedge execlk);
    vectors++; if ({st_done, st_busy, mem_wr_valid} !== 3'b000) begin
      miscompares++; $display("FAIL basic_after_done: got done/busy/valid=%b expected 000", {st_done, st_busy, mem_wr_valid});
    end
    $display("basic: store DEADBEEF @0100 checked cycle by cycle");
  endtask

  task automatic test_backpressure();
    int q0 = wr_q.size();
    int d0 = done_cnt;
    int b0 = busy_cnt;
    bit ok;
    wr_t exp_w;
    mem_wr_ready = 1'b1;
    start_store(32'hDEADBEEF, 16'h0100);
    @(posedge execlk); #1;
    @(posedge execlk); #1;
    mem_wr_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge execlk);
      vectors++;
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 16'h0102 || mem_wr_data !== 8'hAD) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b %h/%h expected v=1 0102/ad", j, mem_wr_valid, mem_wr_addr, mem_wr_data);
      end
      @(posedge execlk); #1;
    end
    mem_wr_ready = 1'b1;
    wait_idle(ok, 50);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got busy expected idle"); end
    vectors++; if (wr_q.size() - q0 !== NB) begin miscompares++; $display("FAIL bp_count: got %0d expected %0d", wr_q.size() - q0, NB); end
    for (int i = 0; i < NB && q0 + i < wr_q.size(); i++) begin
      exp_w = model_wr(32'hDEADBEEF, 16'h0100, i);
      vectors++;
      if (wr_q[q0 + i] !== exp_w) begin miscompares++; $display("FAIL bp_wr%0d: got %h expected %h", i, wr_q[q0 + i], exp_w); end
    end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL bp_done: got %0d expected 1", done_cnt - d0); end
    vectors++; if (busy_cnt - b0 !== 8) begin miscompares++; $display("FAIL bp_busy_cycles: got %0d expected 8", busy_cnt - b0); end
    $display("backpressure: 3 stall cycles on byte 2, busy %0d cycles", busy_cnt - b0);
  endtask

  task automatic test_wrap_snapshot();
    int q0 = wr_q.size();
    bit ok;
    wr_t exp_w;
    mem_wr_ready = 1'b1;
    start_store(32'h11223344, 16'hFFFE);
    acc_out = '0;
    wait_idle(ok, 50);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got busy expected idle"); end
    vectors++; if (wr_q.size() - q0 !== NB) begin miscompares++; $display("FAIL wrap_count: got %0d expected %0d", wr_q.size() - q0, NB); end
    for (int i = 0; i < NB && q0 + i < wr_q.size(); i++) begin
      exp_w = model_wr(32'h11223344, 16'hFFFE, i);
      vectors++;
      if (wr_q[q0 + i] !== exp_w) begin miscompares++; $display("FAIL wrap_wr%0d: got %h expected %h", i, wr_q[q0 + i], exp_w); end
    end
    $display("wrap_snapshot: store 11223344 @FFFE with acc_out cleared after capture");
  endtask

  task automatic test_busy_request();
    logic [DW-1:0] w1 = $urandom;
    logic [AW-1:0] a1 = AW'($urandom);
    logic [DW-1:0] w3 = $urandom;
    logic [AW-1:0] a3 = AW'($urandom);
    int q0 = wr_q.size();
    int d0 = done_cnt;
    bit ok;
    wr_t exp_w;
    mem_wr_ready = 1'b1;
    start_store(w1, a1);
    st_req = 1'b1; acc_out = ~w1; st_addr = ~a1;
    @(posedge execlk); #1;
    st_req = 1'b0;
    @(posedge execlk); #1;
    @(posedge execlk); #1;
    @(posedge execlk); #1;
    st_req = 1'b1;
    @(posedge execlk); #1;
    st_req = 1'b0;
    wait_idle(ok, 50);
    vectors++; if (!ok) begin miscompares++; $display("FAIL busyreq_timeout: got busy expected idle"); end
    repeat (3) @(negedge execlk);
    #1;
    vectors++; if (wr_q.size() - q0 !== NB) begin miscompares++; $display("FAIL busyreq_count: got %0d expected %0d", wr_q.size() - q0, NB); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL busyreq_done: got %0d expected 1", done_cnt - d0); end
    for (int i = 0; i < NB && q0 + i < wr_q.size(); i++) begin
      exp_w = model_wr(w1, a1, i);
      vectors++;
      if (wr_q[q0 + i] !== exp_w) begin miscompares++; $display("FAIL busyreq_wr%0d: got %h expected %h", i, wr_q[q0 + i], exp_w); end
    end
    q0 = wr_q.size();
    d0 = done_cnt;
    start_store(w3, a3);
    wait_idle(ok, 50);
    vectors++; if (!ok) begin miscompares++; $display("FAIL busyreq_next_timeout: got busy expected idle"); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL busyreq_next_done: got %0d expected 1", done_cnt - d0); end
    for (int i = 0; i < NB; i++) begin
      exp_w = model_wr(w3, a3, i);
      vectors++;
      if (q0 + i >= wr_q.size() || wr_q[q0 + i] !== exp_w) begin
        miscompares++; $display("FAIL busyreq_next_wr%0d: got %0d writes expected %h", i, wr_q.size() - q0, exp_w);
      end
    end
    $display("busy_request: requests during SEND/DONE ignored, later request accepted");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w = $urandom;
    logic [AW-1:0] a = AW'($urandom);
    int q0 = wr_q.size();
    int d0 = done_cnt;
    bit ok;
    wr_t exp_w;
    mem_wr_ready = 1'b1;
    start_store(w, a);
    @(posedge execlk); #1;
    @(posedge execlk); #1;
    mem_wr_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (mem_wr_valid !== 1'b0 || st_busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_async: got valid=%b busy=%b expected 0 0", mem_wr_valid, st_busy);
    end
    repeat (3) @(negedge execlk);
    #1;
    vectors++; if (mem_wr_addr !== '0 || mem_wr_data !== '0) begin
      miscompares++; $display("FAIL rstmid_outs: got %h/%h expected 0000/00", mem_wr_addr, mem_wr_data);
    end
    vectors++; if (wr_q.size() - q0 !== 2) begin miscompares++; $display("FAIL rstmid_count: got %0d expected 2", wr_q.size() - q0); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL rstmid_done: got %0d expected 0", done_cnt - d0); end
    for (int i = 0; i < 2 && q0 + i < wr_q.size(); i++) begin
      exp_w = model_wr(w, a, i);
      vectors++;
      if (wr_q[q0 + i] !== exp_w) begin miscompares++; $display("FAIL rstmid_wr%0d: got %h expected %h", i, wr_q[q0 + i], exp_w); end
    end
    @(posedge execlk); #1;
    rst = 1'b1;
    mem_wr_ready = 1'b1;
    @(negedge execlk);
    vectors++; if (st_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got busy=%b expected 0", st_busy); end
    q0 = wr_q.size();
    d0 = done_cnt;
    w = $urandom;
    a = AW'($urandom);
    start_store(w, a);
    wait_idle(ok, 50);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_next_timeout: got busy expected idle"); end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rstmid_next_done: got %0d expected 1", done_cnt - d0); end
    for (int i = 0; i < NB; i++) begin
      exp_w = model_wr(w, a, i);
      vectors++;
      if (q0 + i >= wr_q.size() || wr_q[q0 + i] !== exp_w) begin
        miscompares++; $display("FAIL rstmid_next_wr%0d: got %0d writes expected %h", i, wr_q.size() - q0, exp_w);
      end
    end
    $display("reset_mid: store abandoned after 2 bytes, next store completed");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [DW-1:0] w = $urandom;
      logic [AW-1:0] a = AW'($urandom);
      int q0 = wr_q.size();
      int d0 = done_cnt;
      bit ok = 1'b0;
      wr_t exp_w;
      repeat ($urandom_range(0, 3)) @(posedge execlk);
      start_store(w, a);
      mem_wr_ready = ($urandom % 3) != 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge execlk);
        if (!st_busy) begin ok = 1'b1; break; end
        @(posedge execlk); #1;
        mem_wr_ready = ($urandom % 3) != 0;
        acc_out = $urandom;
      end
      #1;
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand%0d_timeout: got busy expected idle", n); end
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rand%0d_done: got %0d expected 1", n, done_cnt - d0); end
      for (int i = 0; i < NB; i++) begin
        exp_w = model_wr(w, a, i);
        vectors++;
        if (q0 + i >= wr_q.size() || wr_q[q0 + i] !== exp_w) begin
          miscompares++; $display("FAIL rand%0d_wr%0d: got %0d writes expected %h", n, i, wr_q.size() - q0, exp_w);
        end
      end
      $display("random store %0d: word %h @%h", n, w, a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_snapshot();
    test_busy_request();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
